// File: rtl/uart_tx_frame_serializer.sv
// Serializes TX (56-bit) and RES (32-bit) FIFO entries into a byte stream
// with optional source header and XOR checksum trailer, in the uart_clk domain.
module uart_tx_frame_serializer #(
  parameter bit         ADD_HDR  = 1'b1,
  parameter bit         ADD_CSUM = 1'b1,
  parameter logic [7:0] TX_SOF   = 8'hA5,
  parameter logic [7:0] RES_SOF  = 8'h5A
) (
  input  logic        uart_clk,
  input  logic        uart_rst,
  input  logic        enable,
  input  logic        tx_empty_flg,
  input  logic [55:0] tx_read_data,
  output logic        tx_read_en,
  input  logic        res_empty_flg,
  input  logic [31:0] res_read_data,
  output logic        res_read_en,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_src
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_HDR,
    S_DATA,
    S_CSUM
  } state_t;

  state_t      state_q, state_d;
  logic [55:0] sreg_q, sreg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        src_q, src_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        xfer;

  assign xfer = byte_valid & byte_ready;

  // State and datapath registers; reset drops any entry in flight.
  always_ff @(posedge uart_clk or negedge uart_rst) begin
    if (!uart_rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      src_q   <= src_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next-state: round-robin grant in IDLE, then pop, load, and stream bytes.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    src_d   = src_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && (!tx_empty_flg || !res_empty_flg)) begin
          if (!tx_empty_flg && !res_empty_flg) src_d = ~last_q;
          else                                  src_d = ~res_empty_flg;
          last_d  = src_d;
          state_d = S_POP;
        end
      end
      S_POP: state_d = S_WAIT;
      S_WAIT: begin
        sreg_d  = src_q ? {res_read_data, 24'h0} : tx_read_data;
        cnt_d   = src_q ? 3'd4 : 3'd7;
        csum_d  = 8'h00;
        state_d = ADD_HDR ? S_HDR : S_DATA;
      end
      S_HDR: begin
        if (xfer) state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          sreg_d = {sreg_q[47:0], 8'h00};
          csum_d = csum_q ^ sreg_q[55:48];
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (ADD_CSUM) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte mux: header, current MSB data byte, or running checksum.
  always_comb begin
    byte_data = 8'h00;
    case (state_q)
      S_HDR:   byte_data = src_q ? RES_SOF : TX_SOF;
      S_DATA:  byte_data = sreg_q[55:48];
      S_CSUM:  byte_data = csum_q;
      default: byte_data = 8'h00;
    endcase
  end

  assign byte_valid  = (state_q == S_HDR) || (state_q == S_DATA) ||
                       (state_q == S_CSUM);
  assign tx_read_en  = (state_q == S_POP) && !src_q;
  assign res_read_en = (state_q == S_POP) && src_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;
  assign frame_src   = src_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: FIFO models, byte monitor and a
// queue-based reference of the framed byte stream and grant order.
module tb_uart_tx_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, rdy_a, en_b, rdy_b;
  logic tx_re_a, res_re_a, bv_a, busy_a, fd_a, fs_a;
  logic tx_re_b, res_re_b, bv_b, busy_b, fd_b, fs_b;
  logic [7:0] bd_a, bd_b;

  logic [55:0] txm_a [64];
  logic [31:0] resm_a [64];
  logic [55:0] txm_b [64];
  logic [55:0] txd_a = '0;
  logic [31:0] resd_a = '0;
  logic [55:0] txd_b = '0;
  int txw_a = 0, txr_a = 0, resw_a = 0, resr_a = 0;
  int txw_b = 0, txr_b = 0;
  logic tx_empty_a, res_empty_a, tx_empty_b;

  assign tx_empty_a  = (txr_a == txw_a);
  assign res_empty_a = (resr_a == resw_a);
  assign tx_empty_b  = (txr_b == txw_b);

  logic [7:0] got_a [$];
  logic [7:0] got_b [$];
  logic [7:0] exp_q [$];
  logic pop_a [$];
  logic pop_b [$];
  logic dsrc_a [$];
  logic dsrc_b [$];
  logic exp_src_q [$];
  logic [55:0] mtx_q [$];
  logic [31:0] mres_q [$];
  logic m_last;
  int vectors = 0;
  int miscompares = 0;

  uart_tx_frame_serializer dut_a (
    .uart_clk(clk), .uart_rst(rst_n), .enable(en_a),
    .tx_empty_flg(tx_empty_a), .tx_read_data(txd_a),
    .tx_read_en(tx_re_a),
    .res_empty_flg(res_empty_a), .res_read_data(resd_a),
    .res_read_en(res_re_a),
    .byte_data(bd_a), .byte_valid(bv_a), .byte_ready(rdy_a),
    .busy(busy_a), .frame_done(fd_a), .frame_src(fs_a)
  );

  uart_tx_frame_serializer #(.ADD_HDR(1'b0), .ADD_CSUM(1'b0)) dut_b (
    .uart_clk(clk), .uart_rst(rst_n), .enable(en_b),
    .tx_empty_flg(tx_empty_b), .tx_read_data(txd_b),
    .tx_read_en(tx_re_b),
    .res_empty_flg(1'b1), .res_read_data(32'h0),
    .res_read_en(res_re_b),
    .byte_data(bd_b), .byte_valid(bv_b), .byte_ready(rdy_b),
    .busy(busy_b), .frame_done(fd_b), .frame_src(fs_b)
  );

  // FIFO read ports and monitor for instance A
  always @(posedge clk) begin
    if (tx_re_a) begin
      txd_a <= txm_a[txr_a % 64];
      txr_a <= txr_a + 1;
      pop_a.push_back(1'b0);
    end
    if (res_re_a) begin
      resd_a <= resm_a[resr_a % 64];
      resr_a <= resr_a + 1;
      pop_a.push_back(1'b1);
    end
    if (bv_a && rdy_a) got_a.push_back(bd_a);
    if (fd_a) dsrc_a.push_back(fs_a);
  end

  // FIFO read port and monitor for instance B
  always @(posedge clk) begin
    if (tx_re_b) begin
      txd_b <= txm_b[txr_b % 64];
      txr_b <= txr_b + 1;
      pop_b.push_back(1'b0);
    end
    if (res_re_b) pop_b.push_back(1'b1);
    if (bv_b && rdy_b) got_b.push_back(bd_b);
    if (fd_b) dsrc_b.push_back(fs_b);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx_a(input logic [55:0] d, input bit mdl);
    txm_a[txw_a % 64] = d;
    txw_a++;
    if (mdl) mtx_q.push_back(d);
  endtask

  task automatic push_res_a(input logic [31:0] d, input bit mdl);
    resm_a[resw_a % 64] = d;
    resw_a++;
    if (mdl) mres_q.push_back(d);
  endtask

  task automatic push_tx_b(input logic [55:0] d);
    txm_b[txw_b % 64] = d;
    txw_b++;
  endtask

  // Expected bytes of one entry: [header] data bytes MSB first [xor].
  task automatic add_frame(input bit s, input logic [55:0] d,
                           input bit hdr, input bit cs);
    int n;
    logic [7:0] b;
    logic [7:0] x;
    n = s ? 4 : 7;
    x = 8'h00;
    if (hdr) exp_q.push_back(s ? 8'h5A : 8'hA5);
    for (int i = 0; i < n; i++) begin
      b = 8'(d >> (8 * (n - 1 - i)));
      x = x ^ b;
      exp_q.push_back(b);
    end
    if (cs) exp_q.push_back(x);
  endtask

  // Grant order: alternate when both pending, else whichever is pending.
  task automatic model_drain();
    bit s;
    while (mtx_q.size() > 0 || mres_q.size() > 0) begin
      if (mtx_q.size() > 0 && mres_q.size() > 0) s = !m_last;
      else s = (mres_q.size() > 0);
      m_last = s;
      exp_src_q.push_back(s);
      if (s) add_frame(1'b1, {24'h0, mres_q.pop_front()}, 1'b1, 1'b1);
      else   add_frame(1'b0, mtx_q.pop_front(), 1'b1, 1'b1);
    end
  endtask

  task automatic wait_a(input int target, input bit rnd);
    int c = 0;
    while ((got_a.size() < target || busy_a) && c < 2000) begin
      @(negedge clk);
      c++;
      if (rnd) rdy_a = ($urandom_range(0, 3) != 0);
    end
    rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    check("wait_a_in_budget", c < 2000, 1);
  endtask

  task automatic wait_b(input int target);
    int c = 0;
    while ((got_b.size() < target || busy_b) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check("wait_b_in_budget", c < 2000, 1);
  endtask

  task automatic wait_cnt(input bit sel, input int target);
    int c = 0;
    while ((sel ? got_b.size() : got_a.size()) < target && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("byte_count_reached", c < 500, 1);
  endtask

  task automatic cmp_bytes(input bit sel, input int base);
    int n;
    n = sel ? got_b.size() - base : got_a.size() - base;
    check("stream_len", n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (sel) check("stream_byte_b", got_b[base + i], exp_q[i]);
      else     check("stream_byte_a", got_a[base + i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic cmp_src(input int pb, input int db);
    check("pop_count", pop_a.size() - pb, exp_src_q.size());
    check("done_count", dsrc_a.size() - db, exp_src_q.size());
    for (int i = 0; i < exp_src_q.size(); i++) begin
      check("pop_src", pop_a[pb + i], exp_src_q[i]);
      check("done_src", dsrc_a[db + i], exp_src_q[i]);
    end
    exp_src_q.delete();
  endtask

  task automatic check_reset();
    check("rst_byte_valid", bv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_tx_read_en", tx_re_a, 0);
    check("rst_res_read_en", res_re_a, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_frame_src", fs_a, 0);
    check("rst_byte_data", bd_a, 0);
  endtask

  function automatic logic [55:0] rnd56();
    return {24'($urandom()), $urandom()};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int base, pb, db, pbb, dbb, nt, nr;
    logic [55:0] d1, d2;
    rst_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    m_last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Single TX frame, with latency checks
    base = got_a.size(); pb = pop_a.size(); db = dsrc_a.size();
    push_tx_a(56'hDEADBEEF001234, 1'b1);
    en_a = 1'b1;
    @(negedge clk);
    check("t1_pop_strobe", tx_re_a, 1);
    @(negedge clk);
    check("t1_wait_no_valid", bv_a, 0);
    check("t1_pop_one_cycle", tx_re_a, 0);
    @(negedge clk);
    check("t1_hdr_valid", bv_a, 1);
    check("t1_hdr_byte", bd_a, 8'hA5);
    model_drain();
    wait_a(base + 9, 1'b0);
    check("t1_csum", got_a[base + 8], 8'h04);
    cmp_bytes(1'b0, base);
    cmp_src(pb, db);
    check("t1_frame_src", fs_a, 0);

    // Single RES word
    base = got_a.size(); pb = pop_a.size(); db = dsrc_a.size();
    push_res_a(32'hCAFEF00D, 1'b1);
    model_drain();
    wait_a(base + 6, 1'b0);
    check("t2_csum", got_a[base + 5], 8'hC9);
    cmp_bytes(1'b0, base);
    cmp_src(pb, db);
    check("t2_frame_src", fs_a, 1);

    // Back-pressure after the third byte
    base = got_a.size(); pb = pop_a.size(); db = dsrc_a.size();
    push_tx_a(56'hDEADBEEF001234, 1'b1);
    model_drain();
    wait_cnt(1'b0, base + 3);
    rdy_a = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", bv_a, 1);
      check("t3_hold_data", bd_a, 8'hBE);
    end
    rdy_a = 1'b1;
    wait_a(base + 9, 1'b0);
    cmp_bytes(1'b0, base);
    cmp_src(pb, db);

    // Both FIFOs loaded after reset: RES wins first tie
    rst_n = 1'b0;
    en_a = 1'b0;
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    m_last = 1'b0;
    @(negedge clk);
    base = got_a.size(); pb = pop_a.size(); db = dsrc_a.size();
    push_tx_a(rnd56(), 1'b1);
    push_tx_a(rnd56(), 1'b1);
    push_res_a($urandom(), 1'b1);
    push_res_a($urandom(), 1'b1);
    model_drain();
    check("t4_first_grant_res", exp_src_q[0], 1);
    en_a = 1'b1;
    wait_a(base + exp_q.size(), 1'b0);
    cmp_bytes(1'b0, base);
    cmp_src(pb, db);

    // Random mixes with random back-pressure
    for (int r = 0; r < 8; r++) begin
      base = got_a.size(); pb = pop_a.size(); db = dsrc_a.size();
      nt = $urandom_range(0, 3);
      nr = $urandom_range(0, 3);
      if (nt == 0 && nr == 0) nt = 1;
      for (int k = 0; k < nt; k++) push_tx_a(rnd56(), 1'b1);
      for (int k = 0; k < nr; k++) push_res_a($urandom(), 1'b1);
      model_drain();
      wait_a(base + exp_q.size(), 1'b1);
      cmp_bytes(1'b0, base);
      cmp_src(pb, db);
    end

    // Reset in the middle of a data byte run
    base = got_a.size();
    push_tx_a(rnd56(), 1'b0);
    wait_cnt(1'b0, base + 3);
    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b0;
    pb = pop_a.size();
    repeat (10) @(negedge clk);
    check("t5_no_pop_when_empty", pop_a.size() - pb, 0);
    check("t5_idle_after_reset", busy_a, 0);
    base = got_a.size(); pb = pop_a.size(); db = dsrc_a.size();
    push_tx_a(rnd56(), 1'b1);
    model_drain();
    wait_a(base + 9, 1'b0);
    cmp_bytes(1'b0, base);
    cmp_src(pb, db);

    // No header/checksum instance; enable dropped mid-entry
    base = got_b.size(); pbb = pop_b.size(); dbb = dsrc_b.size();
    d1 = rnd56();
    d2 = rnd56();
    push_tx_b(d1);
    push_tx_b(d2);
    add_frame(1'b0, d1, 1'b0, 1'b0);
    en_b = 1'b1;
    wait_cnt(1'b1, base + 1);
    en_b = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_stalled_idle", busy_b, 0);
    check("t6_one_pop", pop_b.size() - pbb, 1);
    check("t6_one_done", dsrc_b.size() - dbb, 1);
    cmp_bytes(1'b1, base);
    base = got_b.size();
    add_frame(1'b0, d2, 1'b0, 1'b0);
    en_b = 1'b1;
    wait_b(base + 7);
    cmp_bytes(1'b1, base);
    check("t6_two_pops", pop_b.size() - pbb, 2);
    check("t6_two_done", dsrc_b.size() - dbb, 2);
    check("t6_pop_src_tx", pop_b[pbb + 1], 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
